// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
// Contents: fetch FSM state enum, instruction size, NOP encoding, default reset PC,
// and a word-alignment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } fetch_state_e;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction-memory read bus (req/gnt/rvalid handshake)
// Signals: req/addr from the fetch unit, gnt/rvalid/rdata from memory.
// master: fetch unit side; slave: instruction memory side.
interface fetch_if;

  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter register with load and increment ports
// Ports: clk_i, rst_i (sync, active-high), load_i/load_val_i (target load),
// inc_i/inc_base_i (pc <= inc_base_i + 4), pc_o (current PC).
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        inc_i,
  input  logic [31:0] inc_base_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;

  // Increment is relative to the fetched address rather than pc_q so the PC
  // always follows the instruction that was actually fetched; wraps mod 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= load_val_i;
    end else if (inc_i) begin
      pc_q <= inc_base_i + 32'(INSTR_BYTES);
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC ownership and one-word memory reads
// Ports: clk_i, rst_i (sync, active-high); fetch_start_i, pc_load_i, pc_next_i from
// the controller; pc_o, busy_o status; mem (fetch_if.master) memory bus;
// ir_en_o/ir_data_o to the instruction register; fault_o misaligned-fetch pulse;
// fetch_cnt_o completed-fetch count.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fetch_start_i,
  input  logic             pc_load_i,
  input  logic [31:0]      pc_next_i,
  output logic [31:0]      pc_o,
  output logic             busy_o,
  fetch_if.master          mem,
  output logic             ir_en_o,
  output logic [31:0]      ir_data_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  fetch_state_e     state_q;
  logic [31:0]      addr_q;
  logic             req_q;
  logic             ir_en_q;
  logic             fault_q;
  logic [31:0]      ir_data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      pc;
  logic [31:0]      fetch_addr;

  // A same-cycle load redirects the fetch to the new target.
  always_comb begin
    fetch_addr = pc_load_i ? pc_next_i : pc;
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (state_q == S_IDLE && pc_load_i),
    .load_val_i (pc_next_i),
    .inc_i      (state_q == S_DONE),
    .inc_base_i (addr_q),
    .pc_o       (pc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= RESET_PC;
      req_q     <= 1'b0;
      ir_en_q   <= 1'b0;
      fault_q   <= 1'b0;
      ir_data_q <= NOP_INSTR;
      cnt_q     <= '0;
    end else begin
      ir_en_q <= 1'b0;
      fault_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (fetch_start_i) begin
            if (!is_word_aligned(fetch_addr)) begin
              fault_q <= 1'b1;
            end else begin
              addr_q  <= fetch_addr;
              req_q   <= 1'b1;
              state_q <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem.gnt) begin
            req_q   <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // ir_en is raised here so it is high for exactly the DONE cycle.
          if (mem.rvalid) begin
            ir_data_q <= mem.rdata;
            ir_en_q   <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          cnt_q   <= cnt_q + CNT_W'(1);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pc_o        = pc;
  assign busy_o      = (state_q != S_IDLE);
  assign mem.req     = req_q;
  assign mem.addr    = addr_q;
  assign ir_en_o     = ir_en_q;
  assign ir_data_o   = ir_data_q;
  assign fault_o     = fault_q;
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_start;
  logic        pc_load;
  logic [31:0] pc_next;
  logic [31:0] pc;
  logic        busy;
  logic        ir_en;
  logic [31:0] ir_data;
  logic        fault;
  logic [31:0] fetch_cnt;

  fetch_if mem ();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (32)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .fetch_start_i (fetch_start),
    .pc_load_i     (pc_load),
    .pc_next_i     (pc_next),
    .pc_o          (pc),
    .busy_o        (busy),
    .mem           (mem),
    .ir_en_o       (ir_en),
    .ir_data_o     (ir_data),
    .fault_o       (fault),
    .fetch_cnt_o   (fetch_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int ir_en_pulses = 0;
  int both_high = 0;
  int exp_pulses = 0;

  always @(posedge clk) begin
    if (ir_en) ir_en_pulses++;
    if (ir_en && fault) both_high++;
  end

  typedef struct {
    logic        ld;
    logic [31:0] nxt;
    int          gw;
    int          rw;
    logic [31:0] rd;
    logic        spam;
    logic [31:0] e_addr;
    logic        e_fault;
    logic [31:0] e_pc;
    logic [31:0] e_ir;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl [7];

  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] m_ir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // One controller fetch request with a scripted memory response.
  // gw: cycles gnt is held low in REQ; rw: idle WAIT cycles before rvalid.
  task automatic run_fetch(input logic ld, input logic [31:0] nxt, input int gw, input int rw,
                           input logic [31:0] rd, input logic spam, input logic [31:0] e_addr,
                           input logic e_fault, input logic [31:0] e_pc, input logic [31:0] e_ir,
                           input logic [31:0] e_cnt);
    chk1("idle_before_start", busy, 1'b0);
    fetch_start = 1'b1;
    pc_load     = ld;
    pc_next     = nxt;
    @(negedge clk);
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    pc_next     = $urandom;
    if (e_fault) begin
      chk1("fault_pulse", fault, 1'b1);
      chk1("fault_no_req", mem.req, 1'b0);
      chk1("fault_no_ir_en", ir_en, 1'b0);
      chk1("fault_not_busy", busy, 1'b0);
      @(negedge clk);
      chk1("fault_one_cycle", fault, 1'b0);
      chk1("fault_no_req_later", mem.req, 1'b0);
      chk("fault_pc", pc, e_pc);
      chk("fault_ir_held", ir_data, e_ir);
      chk("fault_cnt", fetch_cnt, e_cnt);
    end else begin
      chk1("req_asserted", mem.req, 1'b1);
      chk("req_addr", mem.addr, e_addr);
      chk1("busy_in_req", busy, 1'b1);
      chk1("no_fault", fault, 1'b0);
      for (int i = 0; i < gw; i++) begin
        if (spam) begin
          fetch_start = 1'b1;
          pc_load     = 1'b1;
          pc_next     = $urandom & 32'hFFFF_FFFC;
        end
        @(negedge clk);
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        chk1("req_held", mem.req, 1'b1);
        chk("addr_stable", mem.addr, e_addr);
      end
      mem.gnt = 1'b1;
      @(negedge clk);
      mem.gnt = 1'b0;
      chk1("req_dropped_after_gnt", mem.req, 1'b0);
      chk1("busy_in_wait", busy, 1'b1);
      for (int i = 0; i < rw; i++) begin
        if (spam) fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        chk1("no_ir_en_in_wait", ir_en, 1'b0);
      end
      mem.rvalid = 1'b1;
      mem.rdata  = rd;
      @(negedge clk);
      mem.rvalid = 1'b0;
      mem.rdata  = $urandom;
      chk1("ir_en_pulse", ir_en, 1'b1);
      chk("ir_data", ir_data, e_ir);
      chk1("no_fault_with_ir_en", fault, 1'b0);
      @(negedge clk);
      chk1("ir_en_one_cycle", ir_en, 1'b0);
      chk1("back_idle", busy, 1'b0);
      chk("pc_after", pc, e_pc);
      chk("cnt_after", fetch_cnt, e_cnt);
      chk("ir_data_held", ir_data, e_ir);
      exp_pulses++;
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 32'h0, 0, 0, 32'h0050_0093, 1'b0, 32'h0, 1'b0, 32'h4, 32'h0050_0093, 32'd1};
    tbl[1] = '{1'b0, 32'h0, 5, 3, 32'h00A0_0113, 1'b1, 32'h4, 1'b0, 32'h8, 32'h00A0_0113, 32'd2};
    tbl[2] = '{1'b1, 32'h100, 1, 1, 32'h0020_81B3, 1'b0, 32'h100, 1'b0, 32'h104, 32'h0020_81B3, 32'd3};
    tbl[3] = '{1'b1, 32'h102, 0, 0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h102, 32'h0020_81B3, 32'd3};
    tbl[4] = '{1'b0, 32'h0, 0, 0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h102, 32'h0020_81B3, 32'd3};
    tbl[5] = '{1'b1, 32'hFFFF_FFFC, 2, 0, 32'h4000_0033, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h4000_0033, 32'd4};
    tbl[6] = '{1'b0, 32'h0, 0, 2, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 32'h4, 32'hDEAD_BEEF, 32'd5};

    rst         = 1'b1;
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    pc_next     = 32'h0;
    mem.gnt     = 1'b0;
    mem.rvalid  = 1'b1;
    mem.rdata   = 32'hBAD0_BAD0;
    repeat (2) @(negedge clk);
    mem.rvalid = 1'b0;
    chk("reset_pc", pc, 32'h0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_req", mem.req, 1'b0);
    chk1("reset_ir_en", ir_en, 1'b0);
    chk1("reset_fault", fault, 1'b0);
    chk("reset_ir_data", ir_data, 32'h0000_0013);
    chk("reset_cnt", fetch_cnt, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      run_fetch(tbl[v].ld, tbl[v].nxt, tbl[v].gw, tbl[v].rw, tbl[v].rd, tbl[v].spam,
                tbl[v].e_addr, tbl[v].e_fault, tbl[v].e_pc, tbl[v].e_ir, tbl[v].e_cnt);
    end

    // Stray rvalid while idle must not be captured.
    mem.rvalid = 1'b1;
    mem.rdata  = 32'h1234_5678;
    @(negedge clk);
    mem.rvalid = 1'b0;
    chk("idle_rvalid_ignored", ir_data, 32'hDEAD_BEEF);
    chk1("idle_rvalid_no_ir_en", ir_en, 1'b0);
    chk1("idle_rvalid_not_busy", busy, 1'b0);

    // Reset while in REQ: request drops the following cycle.
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    chk1("pre_reset_req", mem.req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("reset_in_req_drops_req", mem.req, 1'b0);
    chk1("reset_in_req_idle", busy, 1'b0);

    // Reset while in WAIT, then a stale response.
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    mem.gnt = 1'b1;
    @(negedge clk);
    mem.gnt = 1'b0;
    chk1("wait_before_reset", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem.rvalid = 1'b1;
    mem.rdata  = 32'hCAFE_F00D;
    chk1("reset_in_wait_idle", busy, 1'b0);
    @(negedge clk);
    mem.rvalid = 1'b0;
    chk1("stale_rvalid_no_ir_en", ir_en, 1'b0);
    chk("stale_rvalid_ir_nop", ir_data, 32'h0000_0013);
    chk("reset_in_wait_pc", pc, 32'h0);
    chk("reset_in_wait_cnt", fetch_cnt, 32'h0);
    chk1("reset_in_wait_not_busy", busy, 1'b0);
    @(negedge clk);
    chk1("stale_rvalid_no_late_ir_en", ir_en, 1'b0);

    // Randomized fetches against an architectural model.
    m_pc  = 32'h0;
    m_cnt = 32'h0;
    m_ir  = 32'h0000_0013;
    for (int n = 0; n < 40; n++) begin
      logic        ld;
      logic [31:0] nxt;
      logic [31:0] rd;
      logic [31:0] a;
      logic        flt;
      int          gw;
      int          rw;
      logic        spam;
      ld   = ($urandom_range(0, 3) == 0);
      nxt  = $urandom;
      if ($urandom_range(0, 3) != 0) nxt = nxt & 32'hFFFF_FFFC;
      rd   = $urandom;
      gw   = $urandom_range(0, 4);
      rw   = $urandom_range(0, 4);
      spam = $urandom_range(0, 1) == 1;
      a    = ld ? nxt : m_pc;
      flt  = (a % 4) != 0;
      if (flt) begin
        m_pc = a;
      end else begin
        m_pc  = a + 32'd4;
        m_cnt = m_cnt + 32'd1;
        m_ir  = rd;
      end
      run_fetch(ld, nxt, gw, rw, rd, spam, a, flt, m_pc, m_ir, m_cnt);
    end

    chk("ir_en_fault_overlap", both_high, 0);
    chk("ir_en_pulse_total", ir_en_pulses, exp_pulses);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
